dcache_tag_ctrl: RTL and testbench
==================================

# dcache_tag_ctrl

Controller that owns the port of the data-cache tag store SRAM. It clears the store after reset, serves lookup requests from the load/store unit with hit/miss, dirty and victim information, and sets the dirty bit on store hits. It also installs tags on refill from the miss handler and optionally invalidates the whole store on flush. It sits between the dcache front-end/miss handler and `dcache_tag_store`.

## Interface
- `TAG_WIDTH`, default `ariane_pkg::DCACHE_TAG_WIDTH`: tag bits per line.
- `NUM_WORDS`, default `wt_cache_pkg::DCACHE_NUM_WORDS`: number of cache indexes; power of two.
- Tag-store word layout: bit `TAG_WIDTH+1` = valid, bit `TAG_WIDTH` = dirty, `[TAG_WIDTH-1:0]` = tag. Width `TSW` = `TAG_WIDTH+2`.
- `IW` = `$clog2(NUM_WORDS)`.
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: lookup request.
- `req_ready_o` out 1: lookup accepted when high together with `req_valid_i`.
- `req_index_i` in IW: lookup index.
- `req_tag_i` in TAG_WIDTH: lookup tag.
- `req_we_i` in 1: request is a store (sets dirty on hit).
- `rsp_valid_o` out 1: one-cycle response pulse.
- `rsp_hit_o` out 1: hit.
- `rsp_dirty_o` out 1: dirty bit of the stored line, pre-update.
- `rsp_victim_valid_o` out 1: valid bit of the stored line.
- `rsp_victim_tag_o` out TAG_WIDTH: stored tag.
- `refill_valid_i` in 1: install request.
- `refill_ready_o` out 1: install performed this cycle.
- `refill_index_i` in IW: install index.
- `refill_tag_i` in TAG_WIDTH: install tag.
- `refill_dirty_i` in 1: install dirty bit.
- `flush_i` in 1: level; invalidate all lines. Held high until `flush_done_o`.
- `flush_done_o` out 1: one-cycle pulse.
- `busy_o` out 1: INIT or FLUSH in progress.
- `ts_en_o` out 1: tag store port enable.
- `ts_we_o` out 1: tag store write enable.
- `ts_addr_o` out IW: tag store address.
- `ts_wdata_o` out TSW: tag store write data.
- `ts_bit_en_o` out TSW: tag store per-bit write enable.
- `ts_rdata_i` in TSW: tag store read data. Valid in the same cycle the read is issued, because the store captures the address on the falling edge.

## Operation
- States and transitions:
  - `INIT`: entered on reset; goes to `IDLE` after the last index is written.
  - `IDLE`: goes to `DIRTY_WR` on a store hit, or to `FLUSH` when `flush_i` is high.
  - `DIRTY_WR`: one cycle, then back to `IDLE`.
  - `FLUSH`: goes to `IDLE` after the last index is written.
- `INIT` and `FLUSH`:
  - An IW+1-bit counter walks index 0 to NUM_WORDS-1, one write per cycle.
  - Each write drives `ts_we_o=1`, `wdata=0` and `bit_en` all ones.
  - `busy_o=1`, `req_ready_o=0`, `refill_ready_o=0`.
  - In `FLUSH`, `flush_done_o` pulses in the cycle of the last write.
- `IDLE` priority: refill > flush > request.
  - Refill: `refill_ready_o=1` combinationally. Write `{1, refill_dirty_i, refill_tag_i}` at `refill_index_i` with `bit_en` all ones. `req_ready_o=0` in the same cycle.
  - Flush start: taken when `flush_i=1` and no refill is pending. `req_ready_o=0`.
  - Request: otherwise `req_ready_o=1`. On acceptance, drive a read (`ts_en_o=1`, `ts_we_o=0`, `ts_addr_o=req_index_i`).
  - Hit condition: `valid & (stored tag == req_tag_i)`, compared combinationally.
  - Response fields are registered at the rising edge.
- `DIRTY_WR`:
  - Writes dirty=1 at the registered index, `bit_en` = dirty bit only.
  - `req_ready_o=0` and `refill_ready_o=0`.
- A store miss causes no write. The miss handler installs the line via refill.
- `ts_en_o=0` in any cycle with no access.

## Timing
- Lookup accepted at edge N: `rsp_*` is valid in cycle N+1, with `rsp_valid_o` high for exactly one cycle.
- Store hit: the dirty write happens in cycle N+1. The next request can be accepted at the end of cycle N+2.
- Back-to-back loads: one accepted per cycle, responses pipelined.
- Refill: single cycle, no response.
- INIT takes NUM_WORDS cycles after reset deasserts. `req_ready_o` first rises in cycle NUM_WORDS+1.
- Reset values: every output is 0 and `ts_*` is forced to 0 while `rst_i` is high. State is `INIT` with the counter at 0.
- `rst_i` asserted mid-FLUSH or mid-INIT: the walk restarts from index 0 in `INIT`. No `flush_done_o` is produced.
- `flush_i` raised during `INIT` or `DIRTY_WR`: held off until `IDLE`.

## Configuration
- `RISCMAKERS_DCACHE_FLUSH_EN` defined: the `FLUSH` state and the flush path are compiled in.
- Without it:
  - `flush_i` is ignored.
  - `flush_done_o` is tied to 0.
  - `busy_o` reflects `INIT` only.

## Test plan
All scenarios use bench parameters NUM_WORDS=16, TAG_WIDTH=8; dirty = bit 8, valid = bit 9.
- Reset for 2 cycles, then release:
  - 16 writes to addr 0..15 with `wdata=0` and `bit_en=0x3FF`.
  - `busy_o` falls and `req_ready_o` rises in cycle 17.
  - A lookup at index 5 gives `hit=0`, `victim_valid=0`.
- Refill idx 3, tag 0xA5, dirty 0, then a load idx 3 tag 0xA5:
  - `rsp_valid` one cycle later with `hit=1`, `dirty=0`.
  - No write is issued.
- Store idx 3 tag 0xA5:
  - `hit=1`; the next cycle has `ts_we_o=1`, `addr=3`, `bit_en=0x100`, `wdata[8]=1`, `req_ready_o=0`.
  - A following load gives `dirty=1`.
- Store idx 3 tag 0x5A:
  - `hit=0`, `victim_valid=1`, `victim_tag=0xA5`, `dirty=1`.
  - No tag-store write follows.
- `refill_valid_i` and `req_valid_i` high in the same cycle:
  - `refill_ready_o=1` and `req_ready_o=0`.
  - The request is accepted the next cycle.
- Hold `flush_i` (macro defined):
  - 16 zero writes, with `flush_done_o` pulsing on the addr-15 write.
  - A load idx 3 tag 0xA5 then misses.
  - With the macro undefined: no writes occur and `flush_done_o` stays 0.

Source files
------------

// File: rtl/dcache_tag_ctrl.sv
// Data-cache tag store port owner: clears the store after reset, serves lookups, sets dirty on store hits, installs refills.
// Optional whole-store invalidate on flush_i when RISCMAKERS_DCACHE_FLUSH_EN is defined.
module dcache_tag_ctrl #(
    parameter  int unsigned TAG_WIDTH = 44,
    parameter  int unsigned NUM_WORDS = 256,
    localparam int unsigned TSW       = TAG_WIDTH + 2,
    localparam int unsigned IW        = $clog2(NUM_WORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [IW-1:0]        req_index_i,
    input  logic [TAG_WIDTH-1:0] req_tag_i,
    input  logic                 req_we_i,
    output logic                 rsp_valid_o,
    output logic                 rsp_hit_o,
    output logic                 rsp_dirty_o,
    output logic                 rsp_victim_valid_o,
    output logic [TAG_WIDTH-1:0] rsp_victim_tag_o,
    input  logic                 refill_valid_i,
    output logic                 refill_ready_o,
    input  logic [IW-1:0]        refill_index_i,
    input  logic [TAG_WIDTH-1:0] refill_tag_i,
    input  logic                 refill_dirty_i,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic                 busy_o,
    output logic                 ts_en_o,
    output logic                 ts_we_o,
    output logic [IW-1:0]        ts_addr_o,
    output logic [TSW-1:0]       ts_wdata_o,
    output logic [TSW-1:0]       ts_bit_en_o,
    input  logic [TSW-1:0]       ts_rdata_i
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_DIRTY_WR, S_FLUSH} state_t;

    localparam logic [IW:0]    LAST       = (IW+1)'(NUM_WORDS - 1);
    localparam logic [TSW-1:0] DIRTY_MASK = TSW'(1) << TAG_WIDTH;

    state_t               r_state, w_next;
    logic [IW:0]          r_cnt, w_cnt_nxt;
    logic [IW-1:0]        r_idx;
    logic                 r_rsp_valid, r_rsp_hit, r_rsp_dirty, r_rsp_vv;
    logic [TAG_WIDTH-1:0] r_rsp_vtag;

    logic                 w_req_ready, w_refill_ready, w_flush_done, w_busy;
    logic                 w_en, w_we;
    logic [IW-1:0]        w_addr;
    logic [TSW-1:0]       w_wdata, w_bit_en;
    logic                 w_hit, w_req_fire, w_flush_req;

`ifdef RISCMAKERS_DCACHE_FLUSH_EN
    assign w_flush_req = flush_i;
`else
    logic w_unused_flush;
    assign w_unused_flush = flush_i;
    assign w_flush_req    = 1'b0;
`endif

    // Store returns read data in the issue cycle, so hit is resolved combinationally.
    assign w_hit      = ts_rdata_i[TSW-1] & (ts_rdata_i[TAG_WIDTH-1:0] == req_tag_i);
    assign w_req_fire = w_req_ready & req_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_dirty <= 1'b0;
            r_rsp_vv    <= 1'b0;
            r_rsp_vtag  <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= w_req_fire;
            if (w_req_fire) begin
                r_rsp_hit   <= w_hit;
                r_rsp_dirty <= ts_rdata_i[TAG_WIDTH];
                r_rsp_vv    <= ts_rdata_i[TSW-1];
                r_rsp_vtag  <= ts_rdata_i[TAG_WIDTH-1:0];
                r_idx       <= req_index_i;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_cnt_nxt      = r_cnt;
        w_req_ready    = 1'b0;
        w_refill_ready = 1'b0;
        w_flush_done   = 1'b0;
        w_busy         = 1'b0;
        w_en           = 1'b0;
        w_we           = 1'b0;
        w_addr         = '0;
        w_wdata        = '0;
        w_bit_en       = '0;
        case (r_state)
            S_INIT: begin
                w_busy    = 1'b1;
                w_en      = 1'b1;
                w_we      = 1'b1;
                w_addr    = r_cnt[IW-1:0];
                w_bit_en  = '1;
                w_cnt_nxt = r_cnt + (IW+1)'(1);
                if (r_cnt == LAST) begin
                    w_next    = S_IDLE;
                    w_cnt_nxt = '0;
                end
            end
            S_IDLE: begin
                if (refill_valid_i) begin
                    w_refill_ready = 1'b1;
                    w_en           = 1'b1;
                    w_we           = 1'b1;
                    w_addr         = refill_index_i;
                    w_wdata        = {1'b1, refill_dirty_i, refill_tag_i};
                    w_bit_en       = '1;
                end else if (w_flush_req) begin
                    w_next    = S_FLUSH;
                    w_cnt_nxt = '0;
                end else begin
                    w_req_ready = 1'b1;
                    if (req_valid_i) begin
                        w_en   = 1'b1;
                        w_addr = req_index_i;
                        if (req_we_i && w_hit)
                            w_next = S_DIRTY_WR;
                    end
                end
            end
            S_DIRTY_WR: begin
                w_en     = 1'b1;
                w_we     = 1'b1;
                w_addr   = r_idx;
                w_wdata  = DIRTY_MASK;
                w_bit_en = DIRTY_MASK;
                w_next   = S_IDLE;
            end
`ifdef RISCMAKERS_DCACHE_FLUSH_EN
            S_FLUSH: begin
                w_busy    = 1'b1;
                w_en      = 1'b1;
                w_we      = 1'b1;
                w_addr    = r_cnt[IW-1:0];
                w_bit_en  = '1;
                w_cnt_nxt = r_cnt + (IW+1)'(1);
                if (r_cnt == LAST) begin
                    w_flush_done = 1'b1;
                    w_next       = S_IDLE;
                    w_cnt_nxt    = '0;
                end
            end
`endif
            default: w_next = S_INIT;
        endcase
    end

    // Everything is forced quiet while reset is held.
    assign req_ready_o        = ~rst_i & w_req_ready;
    assign refill_ready_o     = ~rst_i & w_refill_ready;
    assign flush_done_o       = ~rst_i & w_flush_done;
    assign busy_o             = ~rst_i & w_busy;
    assign rsp_valid_o        = ~rst_i & r_rsp_valid;
    assign rsp_hit_o          = ~rst_i & r_rsp_hit;
    assign rsp_dirty_o        = ~rst_i & r_rsp_dirty;
    assign rsp_victim_valid_o = ~rst_i & r_rsp_vv;
    assign rsp_victim_tag_o   = rst_i ? '0 : r_rsp_vtag;
    assign ts_en_o            = ~rst_i & w_en;
    assign ts_we_o            = ~rst_i & w_we;
    assign ts_addr_o          = rst_i ? '0 : w_addr;
    assign ts_wdata_o         = rst_i ? '0 : w_wdata;
    assign ts_bit_en_o        = rst_i ? '0 : w_bit_en;
endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Directed bench for dcache_tag_ctrl with a behavioural tag-store SRAM (NUM_WORDS=16, TAG_WIDTH=8).
module tb_dcache_tag_ctrl;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_valid_i = 1'b0, req_we_i = 1'b0;
    logic [3:0] req_index_i = '0, refill_index_i = '0;
    logic [7:0] req_tag_i = '0, refill_tag_i = '0;
    logic       refill_valid_i = 1'b0, refill_dirty_i = 1'b0, flush_i = 1'b0;
    logic       req_ready_o, rsp_valid_o, rsp_hit_o, rsp_dirty_o, rsp_victim_valid_o;
    logic [7:0] rsp_victim_tag_o;
    logic       refill_ready_o, flush_done_o, busy_o, ts_en_o, ts_we_o;
    logic [3:0] ts_addr_o;
    logic [9:0] ts_wdata_o, ts_bit_en_o, ts_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    dcache_tag_ctrl #(.TAG_WIDTH(8), .NUM_WORDS(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_index_i(req_index_i),
        .req_tag_i(req_tag_i), .req_we_i(req_we_i),
        .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_dirty_o(rsp_dirty_o),
        .rsp_victim_valid_o(rsp_victim_valid_o), .rsp_victim_tag_o(rsp_victim_tag_o),
        .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
        .refill_index_i(refill_index_i), .refill_tag_i(refill_tag_i), .refill_dirty_i(refill_dirty_i),
        .flush_i(flush_i), .flush_done_o(flush_done_o), .busy_o(busy_o),
        .ts_en_o(ts_en_o), .ts_we_o(ts_we_o), .ts_addr_o(ts_addr_o),
        .ts_wdata_o(ts_wdata_o), .ts_bit_en_o(ts_bit_en_o), .ts_rdata_i(ts_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Tag store: starts full of valid 0xFF lines so a missing clear would show up as hits.
    logic [9:0] mem [16] = '{default: 10'h3FF};
    assign ts_rdata_i = mem[ts_addr_o];
    always @(posedge clk_i)
        if (ts_en_o && ts_we_o)
            mem[ts_addr_o] <= (mem[ts_addr_o] & ~ts_bit_en_o) | (ts_wdata_o & ts_bit_en_o);

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Present a lookup at a negedge, check it is accepted as a read, return just after the accepting edge.
    task automatic issue(input logic [3:0] idx, input logic [7:0] tag, input logic we);
        req_valid_i = 1'b1; req_index_i = idx; req_tag_i = tag; req_we_i = we;
        #1;
        chk("req_ready", 32'(req_ready_o), 1);
        chk("rd_en", 32'(ts_en_o), 1);
        chk("rd_we", 32'(ts_we_o), 0);
        chk("rd_addr", 32'(ts_addr_o), 32'(idx));
        @(negedge clk_i);
        req_valid_i = 1'b0; req_we_i = 1'b0;
        #1;
    endtask

    task automatic rsp(input string nm, input logic hit, input logic dirty, input logic vv, input logic [7:0] vtag);
        chk({nm, ".valid"}, 32'(rsp_valid_o), 1);
        chk({nm, ".hit"}, 32'(rsp_hit_o), 32'(hit));
        chk({nm, ".dirty"}, 32'(rsp_dirty_o), 32'(dirty));
        chk({nm, ".vvalid"}, 32'(rsp_victim_valid_o), 32'(vv));
        chk({nm, ".vtag"}, 32'(rsp_victim_tag_o), 32'(vtag));
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst.busy", 32'(busy_o), 0);
        chk("rst.ts_en", 32'(ts_en_o), 0);
        chk("rst.req_ready", 32'(req_ready_o), 0);
        chk("rst.rsp_valid", 32'(rsp_valid_o), 0);
        rst_i = 1'b0;

        // INIT walk
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("init.we", 32'({ts_en_o, ts_we_o}), 3);
            chk("init.addr", 32'(ts_addr_o), 32'(i));
            chk("init.wdata", 32'(ts_wdata_o), 0);
            chk("init.bit_en", 32'(ts_bit_en_o), 32'h3FF);
            chk("init.busy", 32'(busy_o), 1);
            chk("init.req_ready", 32'(req_ready_o), 0);
            @(negedge clk_i);
        end
        #1;
        chk("c17.busy", 32'(busy_o), 0);
        chk("c17.req_ready", 32'(req_ready_o), 1);
        @(negedge clk_i);

        issue(4'd5, 8'hFF, 1'b0);
        rsp("lkp5", 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk_i);
        #1 chk("lkp5.pulse", 32'(rsp_valid_o), 0);

        // Refill idx 3, tag A5, clean
        @(negedge clk_i);
        refill_valid_i = 1'b1; refill_index_i = 4'd3; refill_tag_i = 8'hA5; refill_dirty_i = 1'b0;
        #1;
        chk("refill.ready", 32'(refill_ready_o), 1);
        chk("refill.we", 32'({ts_en_o, ts_we_o}), 3);
        chk("refill.addr", 32'(ts_addr_o), 3);
        chk("refill.wdata", 32'(ts_wdata_o), 32'h2A5);
        chk("refill.bit_en", 32'(ts_bit_en_o), 32'h3FF);
        @(negedge clk_i);
        refill_valid_i = 1'b0;
        issue(4'd3, 8'hA5, 1'b0);
        rsp("load3", 1'b1, 1'b0, 1'b1, 8'hA5);
        chk("load3.no_wr", 32'(ts_en_o), 0);

        // Store hit: dirty write in the following cycle
        @(negedge clk_i);
        issue(4'd3, 8'hA5, 1'b1);
        rsp("st3", 1'b1, 1'b0, 1'b1, 8'hA5);
        chk("dw.we", 32'({ts_en_o, ts_we_o}), 3);
        chk("dw.addr", 32'(ts_addr_o), 3);
        chk("dw.bit_en", 32'(ts_bit_en_o), 32'h100);
        chk("dw.wdata8", 32'(ts_wdata_o[8]), 1);
        chk("dw.req_ready", 32'(req_ready_o), 0);
        chk("dw.refill_ready", 32'(refill_ready_o), 0);
        @(negedge clk_i);
        issue(4'd3, 8'hA5, 1'b0);
        rsp("load3d", 1'b1, 1'b1, 1'b1, 8'hA5);

        // Store miss: victim info, no write
        @(negedge clk_i);
        issue(4'd3, 8'h5A, 1'b1);
        rsp("stmiss", 1'b0, 1'b1, 1'b1, 8'hA5);
        chk("stmiss.no_wr", 32'(ts_en_o), 0);
        chk("stmiss.req_ready", 32'(req_ready_o), 1);
        chk("stmiss.mem3", 32'(mem[3]), 32'h3A5);

        // Refill and request together: refill wins, request waits a cycle
        @(negedge clk_i);
        refill_valid_i = 1'b1; refill_index_i = 4'd7; refill_tag_i = 8'h3C; refill_dirty_i = 1'b1;
        req_valid_i = 1'b1; req_index_i = 4'd7; req_tag_i = 8'h3C; req_we_i = 1'b0;
        #1;
        chk("coll.refill_ready", 32'(refill_ready_o), 1);
        chk("coll.req_ready", 32'(req_ready_o), 0);
        chk("coll.wdata", 32'(ts_wdata_o), 32'h33C);
        @(negedge clk_i);
        refill_valid_i = 1'b0;
        #1 chk("coll.no_rsp", 32'(rsp_valid_o), 0);
        issue(4'd7, 8'h3C, 1'b0);
        rsp("coll.rsp", 1'b1, 1'b1, 1'b1, 8'h3C);

        // Back-to-back loads
        @(negedge clk_i);
        req_valid_i = 1'b1; req_index_i = 4'd3; req_tag_i = 8'hA5;
        @(negedge clk_i);
        req_index_i = 4'd7; req_tag_i = 8'h00;
        #1;
        chk("b2b.ready2", 32'(req_ready_o), 1);
        rsp("b2b.r1", 1'b1, 1'b1, 1'b1, 8'hA5);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        #1;
        rsp("b2b.r2", 1'b0, 1'b1, 1'b1, 8'h3C);

`ifdef RISCMAKERS_DCACHE_FLUSH_EN
        @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        chk("fl.start_ready", 32'(req_ready_o), 0);
        chk("fl.start_en", 32'(ts_en_o), 0);
        @(negedge clk_i);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("fl.we", 32'({ts_en_o, ts_we_o}), 3);
            chk("fl.addr", 32'(ts_addr_o), 32'(i));
            chk("fl.wdata", 32'(ts_wdata_o), 0);
            chk("fl.busy", 32'(busy_o), 1);
            chk("fl.done", 32'(flush_done_o), (i == 15) ? 1 : 0);
            if (i == 15) flush_i = 1'b0;
            @(negedge clk_i);
        end
        #1;
        chk("fl.after_busy", 32'(busy_o), 0);
        chk("fl.after_done", 32'(flush_done_o), 0);
        @(negedge clk_i);
        issue(4'd3, 8'hA5, 1'b0);
        rsp("fl.load3", 1'b0, 1'b0, 1'b0, 8'h00);
`else
        @(negedge clk_i);
        flush_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("nofl.en", 32'(ts_en_o), 0);
            chk("nofl.done", 32'(flush_done_o), 0);
            chk("nofl.busy", 32'(busy_o), 0);
            @(negedge clk_i);
        end
        flush_i = 1'b0;
        issue(4'd3, 8'hA5, 1'b0);
        rsp("nofl.load3", 1'b1, 1'b1, 1'b1, 8'hA5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
